// File: rtl/mosquito_wave_scheduler.sv
// Wave sequencer for the mosquito game: spawns waves, credits hits, counts escapes,
// raises the level after clean waves and ends the game once too many mosquitoes get away.
module mosquito_wave_scheduler #(
    parameter int NUM_MOSQ     = 2,
    parameter int GAP_CYCLES   = 12500000,
    parameter int MAX_LEVEL    = 7,
    parameter int ESCAPE_LIMIT = 3
) (
    input  logic                clk25,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_MOSQ-1:0] hit,
    input  logic [NUM_MOSQ-1:0] mosq_alive,
    output logic                reset_mosquito,
    output logic [NUM_MOSQ-1:0] kill,
    output logic [3:0]          speed,
    output logic [2:0]          level,
    output logic [15:0]         score,
    output logic [2:0]          escapes,
    output logic                game_over,
    output logic [2:0]          state
);

    localparam logic [2:0]  S_IDLE    = 3'd0;
    localparam logic [2:0]  S_SPAWN   = 3'd1;
    localparam logic [2:0]  S_ACTIVE  = 3'd2;
    localparam logic [2:0]  S_GAP     = 3'd3;
    localparam logic [2:0]  S_OVER    = 3'd4;

    localparam logic [23:0] GAP_LAST  = (GAP_CYCLES > 1) ? 24'(GAP_CYCLES - 1) : 24'd0;
    localparam logic [2:0]  LEVEL_TOP = 3'(MAX_LEVEL);
    localparam logic [3:0]  ESC_LIMIT = 4'(ESCAPE_LIMIT);

    logic [2:0]          state_q, state_d;
    logic                reset_mosquito_q, reset_mosquito_d;
    logic [NUM_MOSQ-1:0] kill_q, kill_d;
    logic [2:0]          level_q, level_d;
    logic [3:0]          speed_q, speed_d;
    logic [15:0]         score_q, score_d;
    logic [2:0]          escapes_q, escapes_d;
    logic                game_over_q, game_over_d;
    logic [NUM_MOSQ-1:0] alive_q;
    logic [NUM_MOSQ-1:0] hit_flag_q, hit_flag_d;
    logic                wave_escape_q, wave_escape_d;
    logic                armed_q, armed_d;
    logic [23:0]         gap_cnt_q, gap_cnt_d;

    logic [NUM_MOSQ-1:0] validHit;
    logic [NUM_MOSQ-1:0] escapeEv;
    logic [7:0]          hitCount;
    logic [7:0]          escCount;
    logic [3:0]          levelInc;
    logic [23:0]         scoreSum;
    logic [15:0]         scoreSat;
    logic [8:0]          escSum;
    logic [2:0]          escSat;
    logic [2:0]          levelUp;

    // A hit only counts on a live, not-yet-hit slot; a slot dying with the hit is an escape.
    assign validHit = hit & mosq_alive & ~hit_flag_q;
    assign escapeEv = alive_q & ~mosq_alive & ~hit_flag_q;

    always_comb begin
        hitCount = 8'd0;
        escCount = 8'd0;
        for (int i = 0; i < NUM_MOSQ; i++) begin
            hitCount = hitCount + 8'(validHit[i]);
            escCount = escCount + 8'(escapeEv[i]);
        end
    end

    assign levelInc = {1'b0, level_q} + 4'd1;
    assign scoreSum = 24'(score_q) + (24'(hitCount) * 24'(levelInc));
    assign scoreSat = (scoreSum > 24'h00FFFF) ? 16'hFFFF : scoreSum[15:0];
    assign escSum   = 9'(escapes_q) + 9'(escCount);
    assign escSat   = (escSum > 9'd7) ? 3'd7 : escSum[2:0];
    assign levelUp  = (level_q >= LEVEL_TOP) ? level_q : level_q + 3'd1;

    always_comb begin
        state_d          = state_q;
        reset_mosquito_d = 1'b0;
        kill_d           = '0;
        level_d          = level_q;
        score_d          = score_q;
        escapes_d        = escapes_q;
        game_over_d      = game_over_q;
        hit_flag_d       = hit_flag_q;
        wave_escape_d    = wave_escape_q;
        armed_d          = armed_q;
        gap_cnt_d        = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    score_d          = 16'd0;
                    escapes_d        = 3'd0;
                    level_d          = 3'd0;
                    reset_mosquito_d = 1'b1;
                    state_d          = S_SPAWN;
                end
            end
            S_SPAWN: begin
                hit_flag_d    = '0;
                wave_escape_d = 1'b0;
                armed_d       = 1'b0;
                state_d       = S_ACTIVE;
            end
            S_ACTIVE: begin
                armed_d    = 1'b1;
                hit_flag_d = hit_flag_q | validHit;
                kill_d     = validHit;
                score_d    = scoreSat;
                escapes_d  = escSat;
                if (|escapeEv) begin
                    wave_escape_d = 1'b1;
                end
                // The arm cycle skips wave-end: mosq_alive lags reset_mosquito by a cycle.
                if (armed_q && (mosq_alive == '0)) begin
                    if ({1'b0, escSat} >= ESC_LIMIT) begin
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else begin
                        gap_cnt_d = 24'd0;
                        state_d   = S_GAP;
                        if (!wave_escape_d) begin
                            level_d = levelUp;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    reset_mosquito_d = 1'b1;
                    state_d          = S_SPAWN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 24'd1;
                end
            end
            S_OVER: begin
                if (start) begin
                    score_d          = 16'd0;
                    escapes_d        = 3'd0;
                    level_d          = 3'd0;
                    game_over_d      = 1'b0;
                    reset_mosquito_d = 1'b1;
                    state_d          = S_SPAWN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        speed_d = {1'b0, level_d} + 4'd1;
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            reset_mosquito_q <= 1'b0;
            kill_q           <= '0;
            level_q          <= 3'd0;
            speed_q          <= 4'd1;
            score_q          <= 16'd0;
            escapes_q        <= 3'd0;
            game_over_q      <= 1'b0;
            alive_q          <= '0;
            hit_flag_q       <= '0;
            wave_escape_q    <= 1'b0;
            armed_q          <= 1'b0;
            gap_cnt_q        <= 24'd0;
        end else begin
            state_q          <= state_d;
            reset_mosquito_q <= reset_mosquito_d;
            kill_q           <= kill_d;
            level_q          <= level_d;
            speed_q          <= speed_d;
            score_q          <= score_d;
            escapes_q        <= escapes_d;
            game_over_q      <= game_over_d;
            alive_q          <= mosq_alive;
            hit_flag_q       <= hit_flag_d;
            wave_escape_q    <= wave_escape_d;
            armed_q          <= armed_d;
            gap_cnt_q        <= gap_cnt_d;
        end
    end

    assign reset_mosquito = reset_mosquito_q;
    assign kill           = kill_q;
    assign speed          = speed_q;
    assign level          = level_q;
    assign score          = score_q;
    assign escapes        = escapes_q;
    assign game_over      = game_over_q;
    assign state          = state_q;

endmodule

// File: tb/tb_mosquito_wave_scheduler.sv
// Directed bench for mosquito_wave_scheduler: walks through several waves, escapes,
// game over, asynchronous reset and score saturation with hand-computed expectations.
module tb_mosquito_wave_scheduler;

    logic        clk25;
    logic        reset;
    logic        start;
    logic [1:0]  hit;
    logic [1:0]  mosqAlive;
    logic        resetMosquito;
    logic [1:0]  kill;
    logic [3:0]  speed;
    logic [2:0]  level;
    logic [15:0] score;
    logic [2:0]  escapes;
    logic        gameOver;
    logic [2:0]  state;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    mosquito_wave_scheduler #(
        .NUM_MOSQ    (2),
        .GAP_CYCLES  (4),
        .MAX_LEVEL   (7),
        .ESCAPE_LIMIT(3)
    ) dut (
        .clk25         (clk25),
        .reset         (reset),
        .start         (start),
        .hit           (hit),
        .mosq_alive    (mosqAlive),
        .reset_mosquito(resetMosquito),
        .kill          (kill),
        .speed         (speed),
        .level         (level),
        .score         (score),
        .escapes       (escapes),
        .game_over     (gameOver),
        .state         (state)
    );

    initial clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    task automatic applyStimulus(input logic s, input logic [1:0] h, input logic [1:0] a);
        start     = s;
        hit       = h;
        mosqAlive = a;
    endtask

    task automatic stepClock();
        @(posedge clk25);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int expScore;
        int lvl;
        int satWaves;

        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 2'b00);
        #3;
        checkOutput("rstState", 32'(state), 32'd0);
        checkOutput("rstSpeed", 32'(speed), 32'd1);
        checkOutput("rstScore", 32'(score), 32'd0);
        checkOutput("rstMisc", 32'({resetMosquito, kill, level, escapes, gameOver}), 32'd0);
        stepClock();
        stepClock();
        reset = 1'b0;
        stepClock();
        checkOutput("idleHold", 32'(state), 32'd0);

        // Wave 1, level 0: kill slot0 then slot1
        applyStimulus(1'b1, 2'b00, 2'b00);
        stepClock();
        checkOutput("w1Spawn", 32'(state), 32'd1);
        checkOutput("w1RespawnOn", 32'(resetMosquito), 32'd1);
        applyStimulus(1'b0, 2'b00, 2'b11);
        stepClock();
        checkOutput("w1Active", 32'(state), 32'd2);
        checkOutput("w1RespawnOff", 32'(resetMosquito), 32'd0);
        checkOutput("w1Start", 32'({score, level, speed}), 32'({16'd0, 3'd0, 4'd1}));
        applyStimulus(1'b0, 2'b01, 2'b11);
        stepClock();
        checkOutput("w1Kill0", 32'(kill), 32'd1);
        checkOutput("w1Score1", 32'(score), 32'd1);
        applyStimulus(1'b0, 2'b00, 2'b10);
        stepClock();
        checkOutput("w1KillEnd", 32'(kill), 32'd0);
        checkOutput("w1NoEsc", 32'(escapes), 32'd0);
        applyStimulus(1'b0, 2'b10, 2'b10);
        stepClock();
        checkOutput("w1Kill1", 32'(kill), 32'd2);
        checkOutput("w1Score2", 32'(score), 32'd2);
        applyStimulus(1'b0, 2'b00, 2'b00);
        stepClock();
        checkOutput("w1Gap", 32'(state), 32'd3);
        checkOutput("w1Level", 32'({level, speed}), 32'({3'd1, 4'd2}));
        checkOutput("w1Esc", 32'(escapes), 32'd0);
        repeat (3) stepClock();
        checkOutput("w1GapHold", 32'(state), 32'd3);
        stepClock();
        checkOutput("w1GapDone", 32'(state), 32'd1);

        // Wave 2, level 1: double hit, start ignored mid-wave
        applyStimulus(1'b0, 2'b00, 2'b11);
        stepClock();
        applyStimulus(1'b1, 2'b11, 2'b11);
        stepClock();
        checkOutput("w2Score", 32'(score), 32'd6);
        checkOutput("w2StartIgn", 32'(state), 32'd2);
        applyStimulus(1'b0, 2'b00, 2'b00);
        stepClock();
        checkOutput("w2Level", 32'(level), 32'd2);
        repeat (4) stepClock();

        // Wave 3, level 2: double hit worth 6
        applyStimulus(1'b0, 2'b00, 2'b11);
        stepClock();
        applyStimulus(1'b0, 2'b11, 2'b11);
        stepClock();
        checkOutput("w3Double", 32'(score), 32'd12);
        checkOutput("w3Kill", 32'(kill), 32'd3);
        applyStimulus(1'b0, 2'b00, 2'b00);
        stepClock();
        checkOutput("w3Level", 32'({level, speed}), 32'({3'd3, 4'd4}));
        repeat (4) stepClock();

        // Wave 4, level 3: slot0 escapes, level must stay
        applyStimulus(1'b0, 2'b00, 2'b11);
        stepClock();
        applyStimulus(1'b0, 2'b00, 2'b10);
        stepClock();
        checkOutput("w4Esc", 32'(escapes), 32'd1);
        applyStimulus(1'b0, 2'b10, 2'b10);
        stepClock();
        checkOutput("w4Score", 32'(score), 32'd16);
        applyStimulus(1'b0, 2'b00, 2'b00);
        stepClock();
        checkOutput("w4Gap", 32'(state), 32'd3);
        checkOutput("w4LevelHeld", 32'({level, speed}), 32'({3'd3, 4'd4}));
        repeat (4) stepClock();

        // Wave 5: hit while dying is an escape; repeated hit scores nothing
        applyStimulus(1'b0, 2'b00, 2'b11);
        stepClock();
        applyStimulus(1'b0, 2'b01, 2'b10);
        stepClock();
        checkOutput("w5DyingHitEsc", 32'(escapes), 32'd2);
        checkOutput("w5DyingHitScore", 32'({score, 14'd0, kill}), 32'({16'd16, 14'd0, 2'b00}));
        applyStimulus(1'b0, 2'b10, 2'b10);
        stepClock();
        checkOutput("w5Hit", 32'(score), 32'd20);
        applyStimulus(1'b0, 2'b10, 2'b10);
        stepClock();
        checkOutput("w5RepeatHit", 32'({score, 14'd0, kill}), 32'({16'd20, 14'd0, 2'b00}));
        applyStimulus(1'b0, 2'b00, 2'b00);
        stepClock();
        checkOutput("w5Gap", 32'({state, level}), 32'({3'd3, 3'd3}));
        repeat (4) stepClock();

        // Wave 6: third escape lands in the final-death cycle
        applyStimulus(1'b0, 2'b00, 2'b11);
        stepClock();
        applyStimulus(1'b0, 2'b10, 2'b11);
        stepClock();
        checkOutput("w6Score", 32'(score), 32'd24);
        applyStimulus(1'b0, 2'b00, 2'b00);
        stepClock();
        checkOutput("w6Over", 32'(state), 32'd4);
        checkOutput("w6GameOver", 32'(gameOver), 32'd1);
        checkOutput("w6Esc", 32'(escapes), 32'd3);
        stepClock();
        stepClock();
        checkOutput("overHold", 32'({state, score, level, escapes}), 32'({3'd4, 16'd24, 3'd3, 3'd3}));
        applyStimulus(1'b1, 2'b00, 2'b00);
        stepClock();
        checkOutput("restartState", 32'({state, resetMosquito, gameOver}), 32'({3'd1, 1'b1, 1'b0}));
        checkOutput("restartClear", 32'({score, level, escapes, speed}), 32'({16'd0, 3'd0, 3'd0, 4'd1}));

        // Asynchronous reset between edges in ACTIVE
        applyStimulus(1'b0, 2'b00, 2'b11);
        stepClock();
        applyStimulus(1'b0, 2'b01, 2'b11);
        stepClock();
        checkOutput("preRstScore", 32'({score, 14'd0, kill}), 32'({16'd1, 14'd0, 2'b01}));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncRstState", 32'(state), 32'd0);
        checkOutput("asyncRstOut", 32'({resetMosquito, kill, level, score, escapes, gameOver}), 32'd0);
        checkOutput("asyncRstSpeed", 32'(speed), 32'd1);
        #2;
        reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 2'b00);
        stepClock();
        checkOutput("postRstIdle", 32'({state, score}), 32'({3'd0, 16'd0}));

        // Long run to drive the score into saturation
        applyStimulus(1'b1, 2'b00, 2'b00);
        stepClock();
        expScore = 0;
        lvl      = 0;
        satWaves = 0;
        for (int w = 0; w < 5000 && satWaves < 2; w++) begin
            applyStimulus(1'b0, 2'b00, 2'b11);
            stepClock();
            applyStimulus(1'b0, 2'b11, 2'b11);
            stepClock();
            expScore = expScore + 2 * (lvl + 1);
            if (expScore > 65535) expScore = 65535;
            if (expScore >= 65500) checkOutput("satScore", 32'(score), 32'(expScore));
            applyStimulus(1'b0, 2'b00, 2'b00);
            stepClock();
            if (lvl < 7) lvl = lvl + 1;
            repeat (4) stepClock();
            if (expScore == 65535) satWaves++;
        end
        checkOutput("satFinal", 32'(score), 32'h0000FFFF);
        checkOutput("satLevel", 32'({level, speed}), 32'({3'd7, 4'd8}));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
